// File: rtl/step_counter_pkg.sv
// Shared types and defaults for the push-button step counter.
// The debounce state enum, parameter defaults and the dcnt width helper live here.
package step_counter_pkg;

   typedef enum logic [1:0] {IDLE, ARMING, PRESSED, RELEASING} debounce_state_t;

   localparam int WIDTH_DEFAULT     = 4;
   localparam int MAX_COUNT_DEFAULT = 9;
   localparam int DEBOUNCE_DEFAULT  = 16;

   // dcnt spans 0..cycles-1; never narrower than one bit
   function automatic int dcnt_width(input int cycles);
      return (cycles <= 2) ? 1 : $clog2(cycles);
   endfunction

endpackage

// File: rtl/step_counter_button_debouncer.sv
// Two-flop synchronizer plus debounce FSM for a bouncing push-button.
// step strobes combinationally on the ARMING->PRESSED transition.
module button_debouncer
   import step_counter_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
   input  logic clock,
   input  logic clear,
   input  logic button_raw,
   output logic step
);

   localparam int             DW        = dcnt_width(DEBOUNCE_CYCLES);
   localparam logic [DW-1:0]  DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);

   logic [1:0]      sync;
   logic            s;
   debounce_state_t state, state_next;
   logic [DW-1:0]   dcnt, dcnt_next;

   assign s = sync[1];

   always_ff @(posedge clock) begin
      if (clear) begin
         sync  <= '0;
         state <= IDLE;
         dcnt  <= '0;
      end else begin
         sync  <= {sync[0], button_raw};
         state <= state_next;
         dcnt  <= dcnt_next;
      end
   end

   always_comb begin
      state_next = state;
      dcnt_next  = dcnt;
      step       = 1'b0;
      case (state)
         IDLE: begin
            if (s) begin
               state_next = ARMING;
               dcnt_next  = '0;
            end
         end
         ARMING: begin
            if (!s) begin
               state_next = IDLE;
            end else if (dcnt == DCNT_LAST) begin
               state_next = PRESSED;
               step       = 1'b1;
            end else begin
               dcnt_next = dcnt + DW'(1);
            end
         end
         PRESSED: begin
            if (!s) begin
               state_next = RELEASING;
               dcnt_next  = '0;
            end
         end
         RELEASING: begin
            // a bounce back high during release re-enters PRESSED without a new step
            if (s) begin
               state_next = PRESSED;
            end else if (dcnt == DCNT_LAST) begin
               state_next = IDLE;
            end else begin
               dcnt_next = dcnt + DW'(1);
            end
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: rtl/step_counter.sv
// Debounced push-button driving a modulo-(MAX_COUNT+1) up/down counter with
// parallel load; count, step_pulse and carry are all registered.
module step_counter
   import step_counter_pkg::*;
#(
   parameter int WIDTH           = WIDTH_DEFAULT,
   parameter int MAX_COUNT       = MAX_COUNT_DEFAULT,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             button_raw,
   input  logic             dir_up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] count,
   output logic             step_pulse,
   output logic             carry
);

   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);

   logic             step;
   logic [WIDTH-1:0] count_next;
   logic             step_pulse_next;
   logic             carry_next;

   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debouncer (
      .clock      (clock),
      .clear      (clear),
      .button_raw (button_raw),
      .step       (step)
   );

   always_comb begin
      count_next      = count;
      step_pulse_next = 1'b0;
      carry_next      = 1'b0;
      if (load) begin
         // a coincident step is dropped; the debouncer still consumes the press
         count_next = (load_value > MAX_VAL) ? MAX_VAL : load_value;
      end else if (step) begin
         step_pulse_next = 1'b1;
         if (dir_up) begin
            if (count >= MAX_VAL) begin
               count_next = '0;
               carry_next = 1'b1;
            end else begin
               count_next = count + WIDTH'(1);
            end
         end else begin
            if (count == '0) begin
               count_next = MAX_VAL;
               carry_next = 1'b1;
            end else begin
               count_next = count - WIDTH'(1);
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         count      <= '0;
         step_pulse <= 1'b0;
         carry      <= 1'b0;
      end else begin
         count      <= count_next;
         step_pulse <= step_pulse_next;
         carry      <= carry_next;
      end
   end

endmodule
